// File: rtl/rsp_s1_prep_dcest_ctrl_if.sv
// RAM read bus and DC-estimator stream bundle for rsp_s1_prep_dcest_ctrl.
// master: the sequencer. slave: the RAM / estimator side.
interface rsp_s1_prep_dcest_ctrl_if #(
  parameter int READ_RAM_WIDTH = 128,
  parameter int ADDR_WIDTH     = 27
);
  logic                      o_ram_rd_en;
  logic [ADDR_WIDTH-1:0]     o_ram_rd_addr;
  logic [READ_RAM_WIDTH-1:0] i_ram_rd_data;
  logic [READ_RAM_WIDTH-1:0] o_est_data;
  logic                      o_est_valid;
  logic                      o_est_last;
  logic                      o_est_switch;
  logic [31:0]               i_est_y;

  modport master (
    output o_ram_rd_en, o_ram_rd_addr, o_est_data, o_est_valid, o_est_last, o_est_switch,
    input  i_ram_rd_data, i_est_y
  );
  modport slave (
    input  o_ram_rd_en, o_ram_rd_addr, o_est_data, o_est_valid, o_est_last, o_est_switch,
    output i_ram_rd_data, i_est_y
  );
endinterface

// File: rtl/rsp_s1_prep_dcest_ctrl.sv
// Stage-1 DC-estimation sequencer: walks the sample RAM linearly, retimes the
// read strobe into a valid/last stream for the estimator and captures the
// estimator result a fixed number of cycles after the last word.
// Optional feature macro: RSP_DCEST_CTRL_ABORT_EN (adds i_abort).
module rsp_s1_prep_dcest_ctrl #(
  parameter int READ_RAM_WIDTH = 128,
  parameter int ADDR_WIDTH     = 27,
  parameter int RD_LAT         = 2,
  parameter int RES_DELAY      = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [12:0]           i_smp_cnt,
  input  logic [9:0]            i_chp_cnt,
  input  logic [3:0]            i_frm_cnt,
  input  logic                  i_switch,
  input  logic                  i_hold,
  rsp_s1_prep_dcest_ctrl_if.master bus,
  output logic [31:0]           o_result,
  output logic                  o_result_valid,
  output logic                  o_busy,
  output logic                  o_done
`ifdef RSP_DCEST_CTRL_ABORT_EN
  ,
  input  logic                  i_abort
`endif
);

  localparam int CW = $clog2(RES_DELAY + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WAIT_RES, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, off_q, off_d;
  logic [12:0]           smp_max_q, smp_max_d, smp_q, smp_d;
  logic [9:0]            chp_max_q, chp_max_d, chp_q, chp_d;
  logic [3:0]            frm_max_q, frm_max_d, frm_q, frm_d;
  logic                  sw_q, sw_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           result_q, result_d;
  logic [RD_LAT-1:0]     vld_q, lst_q;
  logic [RD_LAT:0]       vld_pipe, lst_pipe;
  logic                  rd_en, last_tag, res_vld, abort_act;
  logic                  est_valid, est_last;
  logic [READ_RAM_WIDTH-1:0] est_data;

`ifdef RSP_DCEST_CTRL_ABORT_EN
  assign abort_act = i_abort && (state_q inside {S_READ, S_DRAIN, S_WAIT_RES});
`else
  assign abort_act = 1'b0;
`endif

  // Read strobe and last tag enter the retiming shift register at index 0.
  assign vld_pipe  = {vld_q, rd_en};
  assign lst_pipe  = {lst_q, last_tag};
  // An abort suppresses whatever is already in flight on the same cycle.
  assign est_valid = vld_q[RD_LAT-1] & ~abort_act;
  assign est_last  = lst_q[RD_LAT-1] & ~abort_act;

  // Next-state, counter walk and result capture.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    off_d     = off_q;
    smp_max_d = smp_max_q;
    chp_max_d = chp_max_q;
    frm_max_d = frm_max_q;
    smp_d     = smp_q;
    chp_d     = chp_q;
    frm_d     = frm_q;
    sw_d      = sw_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    rd_en     = 1'b0;
    last_tag  = 1'b0;
    res_vld   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d    = i_base_addr;
          smp_max_d = i_smp_cnt;
          chp_max_d = i_chp_cnt;
          frm_max_d = i_frm_cnt;
          sw_d      = i_switch;
          off_d     = '0;
          smp_d     = '0;
          chp_d     = '0;
          frm_d     = '0;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (!i_hold) begin
          rd_en = 1'b1;
          off_d = off_q + 1'b1;
          if (smp_q == smp_max_q) begin
            smp_d = '0;
            if (chp_q == chp_max_q) begin
              chp_d = '0;
              if (frm_q == frm_max_q) begin
                last_tag = 1'b1;
                state_d  = S_DRAIN;
              end else begin
                frm_d = frm_q + 1'b1;
              end
            end else begin
              chp_d = chp_q + 1'b1;
            end
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // The last cycle itself counts as 1, so the register holds 2 next.
        if (est_last) begin
          if (RES_DELAY == 1) begin
            result_d = bus.i_est_y;
            res_vld  = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CW'(2);
            state_d = S_WAIT_RES;
          end
        end
      end
      S_WAIT_RES: begin
        if (cnt_q == CW'(RES_DELAY)) begin
          result_d = bus.i_est_y;
          res_vld  = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_act) begin
      state_d  = S_IDLE;
      rd_en    = 1'b0;
      last_tag = 1'b0;
      res_vld  = 1'b0;
      result_d = result_q;
    end
  end

  // State, configuration, counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      off_q     <= '0;
      smp_max_q <= '0;
      chp_max_q <= '0;
      frm_max_q <= '0;
      smp_q     <= '0;
      chp_q     <= '0;
      frm_q     <= '0;
      sw_q      <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      off_q     <= off_d;
      smp_max_q <= smp_max_d;
      chp_max_q <= chp_max_d;
      frm_max_q <= frm_max_d;
      smp_q     <= smp_d;
      chp_q     <= chp_d;
      frm_q     <= frm_d;
      sw_q      <= sw_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // Read-latency retiming shift register; flushed on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (abort_act) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q <= vld_pipe[RD_LAT-1:0];
      lst_q <= lst_pipe[RD_LAT-1:0];
    end
  end

  assign est_data          = bus.i_ram_rd_data;
  assign bus.o_est_data    = est_data;
  assign bus.o_ram_rd_en   = rd_en;
  assign bus.o_ram_rd_addr = base_q + off_q;
  assign bus.o_est_valid   = est_valid;
  assign bus.o_est_last    = est_last;
  assign bus.o_est_switch  = sw_q;
  assign o_result          = result_q;
  assign o_result_valid    = res_vld;
  assign o_busy            = (state_q != S_IDLE);
  assign o_done            = (state_q == S_DONE);

endmodule

// File: tb/tb_rsp_s1_prep_dcest_ctrl.sv
// Directed bench for rsp_s1_prep_dcest_ctrl: a table of jobs with hand-computed
// word counts, addresses and event cycles, plus reset / abort sequences.
module tb_rsp_s1_prep_dcest_ctrl;
  localparam int AW = 27;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start, i_switch, i_hold;
  logic [AW-1:0] i_base_addr;
  logic [12:0]   i_smp_cnt;
  logic [9:0]    i_chp_cnt;
  logic [3:0]    i_frm_cnt;
  logic [31:0]   o_result;
  logic          o_result_valid, o_busy, o_done;
`ifdef RSP_DCEST_CTRL_ABORT_EN
  logic          i_abort;
`endif

  int n_chk = 0;
  int n_fail = 0;

  rsp_s1_prep_dcest_ctrl_if #(.READ_RAM_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rsp_s1_prep_dcest_ctrl #(.READ_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(2), .RES_DELAY(14)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_smp_cnt(i_smp_cnt), .i_chp_cnt(i_chp_cnt), .i_frm_cnt(i_frm_cnt),
    .i_switch(i_switch), .i_hold(i_hold), .bus(bus.master),
    .o_result(o_result), .o_result_valid(o_result_valid), .o_busy(o_busy), .o_done(o_done)
`ifdef RSP_DCEST_CTRL_ABORT_EN
    , .i_abort(i_abort)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    logic [12:0]   smp;
    logic [9:0]    chp;
    logic [3:0]    frm;
    logic          sw;
    int            hold_at;
    int            hold_len;
    int            restart_at;
    logic [31:0]   y;
    int            n_words;
    logic [AW-1:0] last_addr;
    int            first_vld;
    int            done_rel;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs one job; the start cycle is rel 0. Inputs change at negedge, outputs
  // are sampled 1 time unit later.
  task automatic run_vec(input vec_t v, input int idx);
    int rd = 0, vc = 0, lc = 0, last_at = -1, fv = -1, rv = -1, dr = -1;
    int busy_bad = 0, hold_bad = 0, data_bad = 0;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] last_addr_seen = '0;
    logic hold_now;
    @(negedge clk);
    i_base_addr = v.base; i_smp_cnt = v.smp; i_chp_cnt = v.chp; i_frm_cnt = v.frm;
    i_switch = v.sw; i_start = 1'b1; bus.i_est_y = v.y;
    #1 chk($sformatf("v%0d busy_at_start", idx), 64'(o_busy), 64'(0));
    for (int rel = 1; rel <= 300; rel++) begin
      @(negedge clk);
      i_start = (rel == v.restart_at);
      if (rel == v.restart_at) begin
        i_base_addr = 27'h1234; i_smp_cnt = '0; i_chp_cnt = '0; i_frm_cnt = '0;
        i_switch = ~v.sw;
      end
      hold_now = (v.hold_len > 0) && (rel >= v.hold_at) && (rel < v.hold_at + v.hold_len);
      i_hold = hold_now;
      bus.i_ram_rd_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (o_busy !== 1'b1) busy_bad++;
      if (bus.o_est_data !== bus.i_ram_rd_data) data_bad++;
      if (bus.o_ram_rd_en) begin
        if (hold_now) hold_bad++;
        exp_addr = v.base + AW'(rd);
        chk($sformatf("v%0d rd_addr[%0d]", idx, rd), 64'(bus.o_ram_rd_addr), 64'(exp_addr));
        last_addr_seen = bus.o_ram_rd_addr;
        rd++;
      end
      if (bus.o_est_valid) begin
        vc++;
        if (fv < 0) fv = rel;
      end
      if (bus.o_est_last) begin
        lc++;
        last_at = vc;
      end
      if (o_result_valid) rv = rel;
      if (o_done) begin
        dr = rel;
        break;
      end
    end
    chk($sformatf("v%0d done_rel", idx), 64'(dr), 64'(v.done_rel));
    chk($sformatf("v%0d rd_count", idx), 64'(rd), 64'(v.n_words));
    chk($sformatf("v%0d last_rd_addr", idx), 64'(last_addr_seen), 64'(v.last_addr));
    chk($sformatf("v%0d valid_count", idx), 64'(vc), 64'(v.n_words));
    chk($sformatf("v%0d last_count", idx), 64'(lc), 64'(1));
    chk($sformatf("v%0d last_on_final_valid", idx), 64'(last_at), 64'(v.n_words));
    chk($sformatf("v%0d first_valid_rel", idx), 64'(fv), 64'(v.first_vld));
    chk($sformatf("v%0d result_valid_rel", idx), 64'(rv), 64'(v.done_rel - 1));
    chk($sformatf("v%0d result", idx), 64'(o_result), 64'(v.y));
    chk($sformatf("v%0d est_switch", idx), 64'(bus.o_est_switch), 64'(v.sw));
    chk($sformatf("v%0d busy_errs", idx), 64'(busy_bad), 64'(0));
    chk($sformatf("v%0d rd_during_hold", idx), 64'(hold_bad), 64'(0));
    chk($sformatf("v%0d est_data_errs", idx), 64'(data_bad), 64'(0));
    i_hold = 1'b0;
    i_start = 1'b0;
  endtask

  // Watches a quiet window: no reads, valids, done or busy expected.
  task automatic idle_window(input string nm, input int cycles);
    int act = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      #1;
      if (bus.o_ram_rd_en || bus.o_est_valid || bus.o_est_last || o_done || o_busy || o_result_valid)
        act++;
    end
    chk(nm, 64'(act), 64'(0));
  endtask

  initial begin
    //          base         smp chp frm sw hat hlen rst y             n   last_addr    fv done
    vecs[0] = '{27'h0000100, 3,  1,  0,  1, 0,  0,   5,  32'h1234_5678, 8,  27'h0000107, 3, 24};
    vecs[1] = '{27'h0000055, 0,  0,  0,  0, 0,  0,   0,  32'h1234_5678, 1,  27'h0000055, 3, 17};
    vecs[2] = '{27'h0000200, 3,  3,  0,  1, 6,  5,   0,  32'hCAFE_F00D, 16, 27'h000020F, 3, 37};
    vecs[3] = '{27'h7FFFFFE, 1,  1,  1,  0, 0,  0,   0,  32'hA5A5_0001, 8,  27'h0000005, 3, 24};
    vecs[4] = '{27'h0000010, 4,  0,  2,  1, 0,  0,   0,  32'h0BAD_BEEF, 15, 27'h000001E, 3, 31};

    rst_n = 1'b0; i_start = 1'b0; i_switch = 1'b0; i_hold = 1'b0;
    i_base_addr = '0; i_smp_cnt = '0; i_chp_cnt = '0; i_frm_cnt = '0;
    bus.i_ram_rd_data = '0; bus.i_est_y = '0;
`ifdef RSP_DCEST_CTRL_ABORT_EN
    i_abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("reset rd_en", 64'(bus.o_ram_rd_en), 64'(0));
    chk("reset rd_addr", 64'(bus.o_ram_rd_addr), 64'(0));
    chk("reset est_valid", 64'(bus.o_est_valid), 64'(0));
    chk("reset est_last", 64'(bus.o_est_last), 64'(0));
    chk("reset est_switch", 64'(bus.o_est_switch), 64'(0));
    chk("reset result", 64'(o_result), 64'(0));
    chk("reset busy/done/rv", 64'({o_busy, o_done, o_result_valid}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Job 0 carries a restart pulse with new config; nothing must follow it.
    run_vec(vecs[0], 0);
    idle_window("no_second_job", 30);
    // Jobs 1..4 are chained: each starts on the cycle after the previous done.
    for (int i = 1; i < 5; i++) run_vec(vecs[i], i);

    // Reset asserted while in DRAIN (last read at rel 8, last emerges at rel 10).
    @(negedge clk);
    i_base_addr = 27'h300; i_smp_cnt = 3; i_chp_cnt = 1; i_frm_cnt = 0; i_switch = 1'b1;
    i_start = 1'b1;
    for (int rel = 1; rel <= 9; rel++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_drain busy", 64'(o_busy), 64'(0));
    chk("rst_drain valid/last", 64'({bus.o_est_valid, bus.o_est_last}), 64'(0));
    chk("rst_drain rd_en", 64'(bus.o_ram_rd_en), 64'(0));
    chk("rst_drain result", 64'(o_result), 64'(0));
    chk("rst_drain switch", 64'(bus.o_est_switch), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_window("rst_drain quiet", 30);
    run_vec(vecs[1], 5);

`ifdef RSP_DCEST_CTRL_ABORT_EN
    begin
      int late = 0;
      @(negedge clk);
      i_base_addr = 27'h400; i_smp_cnt = 15; i_chp_cnt = 1; i_frm_cnt = 0; i_switch = 1'b0;
      i_start = 1'b1;
      for (int rel = 1; rel <= 4; rel++) begin
        @(negedge clk);
        i_start = 1'b0;
      end
      @(negedge clk);
      i_abort = 1'b1;
      #1;
      chk("abort rd_en same cycle", 64'(bus.o_ram_rd_en), 64'(0));
      chk("abort valid same cycle", 64'(bus.o_est_valid), 64'(0));
      chk("abort rv/done", 64'({o_result_valid, o_done}), 64'(0));
      @(negedge clk);
      i_abort = 1'b0;
      #1;
      chk("abort busy next cycle", 64'(o_busy), 64'(0));
      for (int c = 0; c < 40; c++) begin
        if (bus.o_ram_rd_en || bus.o_est_valid || bus.o_est_last || o_done || o_result_valid) late++;
        @(negedge clk);
        #1;
      end
      chk("abort quiet after", 64'(late), 64'(0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
